// File: rtl/beam_delay_calc.sv
// Turns a steering angle into one transmit delay per array element.
// Drives the sine lookup, scales |sin| into a per-element step and streams the delays out.
module beam_delay_calc #(
    parameter int NUM_ELEMENTS   = 8,
    parameter int ANGLE_WIDTH    = 8,
    parameter int SIN_WIDTH      = 17,
    parameter int SPACING_CYCLES = 1254,
    parameter int DELAY_WIDTH    = 16,
    localparam int IDX_WIDTH     = $clog2(NUM_ELEMENTS)
) (
    input  logic                          clk_in,
    input  logic                          rst_in_n,
    input  logic signed [ANGLE_WIDTH-1:0] angle_in,
    input  logic                          angle_valid_in,
    output logic                          angle_ready_out,
    output logic signed [ANGLE_WIDTH-1:0] lut_angle_out,
    input  logic [SIN_WIDTH-1:0]          sin_value_in,
    input  logic                          sign_bit_in,
    output logic [DELAY_WIDTH-1:0]        delay_out,
    output logic [IDX_WIDTH-1:0]          element_idx_out,
    output logic                          delay_valid_out,
    input  logic                          delay_ready_in,
    output logic                          last_out
);

    localparam int STEP_WIDTH = 16;
    localparam int PROD_WIDTH = SIN_WIDTH + 16;
    localparam int SUM_WIDTH  = ((DELAY_WIDTH > STEP_WIDTH) ? DELAY_WIDTH : STEP_WIDTH) + 1;

    localparam logic signed [ANGLE_WIDTH-1:0] ANGLE_MAX = ANGLE_WIDTH'(90);
    localparam logic signed [ANGLE_WIDTH-1:0] ANGLE_MIN = -ANGLE_MAX;
    localparam logic [DELAY_WIDTH-1:0]        DELAY_MAX = {DELAY_WIDTH{1'b1}};
    localparam logic [IDX_WIDTH-1:0]          IDX_TOP   = IDX_WIDTH'(NUM_ELEMENTS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        STEP,
        EMIT
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic signed [ANGLE_WIDTH-1:0] lut_angle_reg;
    logic [SIN_WIDTH-1:0]          sin_reg;
    logic                          neg_reg;
    logic [STEP_WIDTH-1:0]         step_reg;
    logic [DELAY_WIDTH-1:0]        acc_reg;
    logic [IDX_WIDTH-1:0]          idx_reg;

    logic signed [ANGLE_WIDTH-1:0] angle_clamped;
    logic [PROD_WIDTH-1:0]         product;
    logic [STEP_WIDTH-1:0]         step_next;
    logic [SUM_WIDTH-1:0]          acc_sum;
    logic [DELAY_WIDTH-1:0]        acc_next;
    logic [IDX_WIDTH-1:0]          idx_final;
    logic                          accept;
    logic                          fire;
    logic                          is_final;

    always_comb begin
        angle_clamped = angle_in;
        if (angle_in > ANGLE_MAX) begin
            angle_clamped = ANGLE_MAX;
        end else if (angle_in < ANGLE_MIN) begin
            angle_clamped = ANGLE_MIN;
        end
    end

    // Round-to-nearest scaling of |sin| (Q16) by the element spacing.
    assign product   = PROD_WIDTH'(sin_reg) * PROD_WIDTH'(SPACING_CYCLES) + PROD_WIDTH'(32768);
    assign step_next = STEP_WIDTH'(product >> 16);

    // Accumulator saturates instead of wrapping when the delay range is exceeded.
    assign acc_sum  = SUM_WIDTH'(acc_reg) + SUM_WIDTH'(step_reg);
    assign acc_next = (acc_sum > SUM_WIDTH'(DELAY_MAX)) ? DELAY_MAX : acc_sum[DELAY_WIDTH-1:0];

    // Negative angles walk the array backwards so the nearest element still starts at 0.
    assign idx_final = neg_reg ? '0 : IDX_TOP;
    assign is_final  = (idx_reg == idx_final);
    assign accept    = (state_reg == IDLE) && angle_valid_in;
    assign fire      = (state_reg == EMIT) && delay_ready_in;

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = LOOKUP;
            LOOKUP:  state_next = STEP;
            STEP:    state_next = EMIT;
            EMIT:    if (fire && is_final) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            lut_angle_reg <= '0;
            sin_reg       <= '0;
            neg_reg       <= 1'b0;
            step_reg      <= '0;
            acc_reg       <= '0;
            idx_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        lut_angle_reg <= angle_clamped;
                    end
                end
                LOOKUP: begin
                    sin_reg <= sin_value_in;
                    neg_reg <= sign_bit_in;
                end
                STEP: begin
                    step_reg <= step_next;
                    acc_reg  <= '0;
                    idx_reg  <= neg_reg ? IDX_TOP : '0;
                end
                EMIT: begin
                    if (fire && !is_final) begin
                        acc_reg <= acc_next;
                        idx_reg <= neg_reg ? (idx_reg - IDX_WIDTH'(1)) : (idx_reg + IDX_WIDTH'(1));
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign angle_ready_out = (state_reg == IDLE);
    assign lut_angle_out   = lut_angle_reg;
    assign delay_out       = acc_reg;
    assign element_idx_out = idx_reg;
    assign delay_valid_out = (state_reg == EMIT);
    assign last_out        = (state_reg == EMIT) && is_final;

endmodule
